// File: rtl/boundary_scan_register.sv
// boundary_scan_register: WIDTH-cell IEEE 1149.1-style boundary-scan register
// with capture/shift/update, a Mode mux per pin, and a saturating shift counter.
// Optional build macro BSR_UPDATE_NEGEDGE_EN moves the update-register load to
// the TCK negedge, so it picks up the value left by the preceding shift posedge.

// One boundary-scan cell: capture/shift flop plus its update flop.
module bsr_cell (
  input  logic TCK,
  input  logic TRST_n,
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic sys_in,
  input  logic scan_in,
  output logic scan_q,
  output logic upd_q
);

  // Capture has priority over shift; otherwise the cell holds.
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n)      scan_q <= 1'b0;
    else if (capture) scan_q <= sys_in;
    else if (shift)   scan_q <= scan_in;
  end

`ifdef BSR_UPDATE_NEGEDGE_EN
  // Update on the falling edge: sees the scan value settled after the last posedge.
  always_ff @(negedge TCK or negedge TRST_n) begin
    if (!TRST_n)     upd_q <= 1'b0;
    else if (update) upd_q <= scan_q;
  end
`else
  // Update on the rising edge: sees the scan value before any same-edge shift.
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n)     upd_q <= 1'b0;
    else if (update) upd_q <= scan_q;
  end
`endif

endmodule

module boundary_scan_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             TCK,
  input  logic             TRST_n,
  input  logic             TDI,
  output logic             TDO,
  input  logic [WIDTH-1:0] sys_pin,
  output logic [WIDTH-1:0] module_pin,
  input  logic             CaptureDR,
  input  logic             ShiftDR,
  input  logic             UpdateDR,
  input  logic             Mode,
  output logic [CNT_W-1:0] shift_cnt,
  output logic             pattern_loaded
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] update_reg;
  logic [WIDTH-1:0] scan_in;

  // TDI enters the top cell; data moves toward bit 0 and out on TDO.
  assign scan_in = {TDI, shift_reg[WIDTH-1:1]};

  bsr_cell u_cell [WIDTH-1:0] (
    .TCK     (TCK),
    .TRST_n  (TRST_n),
    .capture (CaptureDR),
    .shift   (ShiftDR),
    .update  (UpdateDR),
    .sys_in  (sys_pin),
    .scan_in (scan_in),
    .scan_q  (shift_reg),
    .upd_q   (update_reg)
  );

  // Shift counter: cleared by capture, counts shifts, saturates at WIDTH.
  always_ff @(posedge TCK or negedge TRST_n) begin
    if (!TRST_n)                            shift_cnt <= '0;
    else if (CaptureDR)                     shift_cnt <= '0;
    else if (ShiftDR && shift_cnt != CNT_MAX) shift_cnt <= shift_cnt + 1'b1;
  end

  assign TDO            = shift_reg[0];
  assign pattern_loaded = (shift_cnt == CNT_MAX);
  assign module_pin     = Mode ? update_reg : sys_pin;

endmodule
